gates_using_mux_unit: RTL and testbench
=======================================

// Module: gates_using_mux_unit
// PURPOSE
//  Logic-gate generator built exclusively from 2:1 multiplexers. Takes two 1-bit
//  inputs a, b; produces AND, OR and NOT(a), plus NAND, NOR, XOR, XNOR.
//  Gate results are registered on clk. Used as a mux-only logic primitive and
//  as a teaching/reference cell for mux-based synthesis checks.
// PARAMETERS
//  (none) - all widths fixed at 1 bit.
// PORTS
//  clk       in   1  system clock; all state updates on rising edge
//  rst       in   1  reset, asynchronous, active-high
//  a         in   1  operand A; also mux select for every 2-input gate
//  b         in   1  operand B
//  and_out   out  1  registered a AND b
//  or_out    out  1  registered a OR b
//  not_out   out  1  registered NOT a
//  nand_out  out  1  registered NOT(a AND b)
//  nor_out   out  1  registered NOT(a OR b)
//  xor_out   out  1  registered a XOR b
//  xnor_out  out  1  registered NOT(a XOR b)
//  valid     out  1  high once outputs hold a result computed from sampled a/b
// BEHAVIOUR
//  Single clock domain, one clock, reset asynchronous and active-high.
//  Datapath: every gate is a 2:1 mux instance y = sel ? i1 : i0, described by
//   a local mux2 submodule; no &, |, ^, ~ or ! operators in the gate datapath.
//   nb       = mux(sel=b, i0=1, i1=0)          (NOT b)
//   not      = mux(sel=a, i0=1, i1=0)
//   and      = mux(sel=a, i0=0, i1=b)
//   or       = mux(sel=a, i0=b, i1=1)
//   nand     = mux(sel=a, i0=1, i1=nb)
//   nor      = mux(sel=a, i0=nb, i1=0)
//   xor      = mux(sel=a, i0=b, i1=nb)
//   xnor     = mux(sel=a, i0=nb, i1=b)
//  Registers: each combinational gate result captured into its output flop on
//   every rising clk edge; latency exactly 1 cycle from a/b to outputs.
//  No enable, no handshake: outputs update every cycle unconditionally.
//  Reset: while rst=1, all seven gate outputs = 0 and valid = 0, immediately
//   (asynchronous), independent of clk. not_out/nand_out/nor_out/xnor_out also
//   reset to 0 (not to their logical value for a=b=0).
//  valid: 0 during reset; set to 1 on first rising edge after rst deasserts;
//   stays 1 until next reset.
//  Reset mid-operation: outputs and valid clear asynchronously; first edge
//   after release reloads from current a/b.
//  Simultaneous a and b change: both sampled at same edge; no ordering issue.
//  Inputs assumed synchronous to clk; no internal synchronisers.
// TESTING
//  Reset: rst=1, a=1 b=1, toggle clk -> all outputs 0, valid 0; assert rst
//   between edges -> outputs clear without a clock edge.
//  a=0 b=0, one edge after reset release -> and0 or0 not1 nand1 nor1 xor0
//   xnor1, valid 1.
//  a=1 b=1 -> next edge: and1 or1 not0 nand0 nor0 xor0 xnor1.
//  a=1 b=0 -> and0 or1 not0 nand1 nor0 xor1 xnor0; then a=0 b=1 -> and0 or1
//   not1 nand1 nor0 xor1 xnor0.
//  Latency: change a/b mid-cycle -> outputs unchanged until next rising edge;
//   sequence 00,11,10,01,10,11 at 1 vector/cycle reproduces truth table 1 late.
//  Structural: lint/synth check confirms gate datapath uses only mux2 instances.

Source files
------------

// File: rtl/gates_using_mux_unit_if.sv
// rtl/gates_using_mux_unit_if.sv - operand and registered gate-result bundle for the mux-only gate cell
`timescale 1ns/1ps
interface gates_using_mux_unit_if;
   logic a;
   logic b;
   logic and_out;
   logic or_out;
   logic not_out;
   logic nand_out;
   logic nor_out;
   logic xor_out;
   logic xnor_out;
   logic valid;

   modport master (
      output a, b,
      input  and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out, valid
   );

   modport slave (
      input  a, b,
      output and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out, valid
   );
endinterface

// File: rtl/gates_using_mux_unit.sv
// rtl/gates_using_mux_unit.sv - logic gates built only from 2:1 muxes, results registered
`timescale 1ns/1ps
module mux2 (
   input  logic sel,
   input  logic i0,
   input  logic i1,
   output logic y
);
   assign y = sel ? i1 : i0;
endmodule

module gates_using_mux_unit (
   input  logic                  clk,
   input  logic                  rst,
   gates_using_mux_unit_if.slave bus
);
   logic nb_c;
   logic not_c;
   logic and_c;
   logic or_c;
   logic nand_c;
   logic nor_c;
   logic xor_c;
   logic xnor_c;

   // a is the select of every two-input gate; b and its mux-made inverse are the data legs
   mux2 u_nb   (.sel(bus.b), .i0(1'b1), .i1(1'b0),  .y(nb_c));
   mux2 u_not  (.sel(bus.a), .i0(1'b1), .i1(1'b0),  .y(not_c));
   mux2 u_and  (.sel(bus.a), .i0(1'b0), .i1(bus.b), .y(and_c));
   mux2 u_or   (.sel(bus.a), .i0(bus.b), .i1(1'b1), .y(or_c));
   mux2 u_nand (.sel(bus.a), .i0(1'b1), .i1(nb_c),  .y(nand_c));
   mux2 u_nor  (.sel(bus.a), .i0(nb_c), .i1(1'b0),  .y(nor_c));
   mux2 u_xor  (.sel(bus.a), .i0(bus.b), .i1(nb_c), .y(xor_c));
   mux2 u_xnor (.sel(bus.a), .i0(nb_c), .i1(bus.b), .y(xnor_c));

   // Inverting outputs also clear to 0 in reset, not to their a=b=0 value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.and_out  <= 1'b0;
         bus.or_out   <= 1'b0;
         bus.not_out  <= 1'b0;
         bus.nand_out <= 1'b0;
         bus.nor_out  <= 1'b0;
         bus.xor_out  <= 1'b0;
         bus.xnor_out <= 1'b0;
         bus.valid    <= 1'b0;
      end else begin
         bus.and_out  <= and_c;
         bus.or_out   <= or_c;
         bus.not_out  <= not_c;
         bus.nand_out <= nand_c;
         bus.nor_out  <= nor_c;
         bus.xor_out  <= xor_c;
         bus.xnor_out <= xnor_c;
         bus.valid    <= 1'b1;
      end
   end
endmodule

// File: tb/tb_gates_using_mux_unit.sv
// tb/tb_gates_using_mux_unit.sv - randomized self-checking bench for gates_using_mux_unit
`timescale 1ns/1ps
module tb_gates_using_mux_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   gates_using_mux_unit_if bus ();

   gates_using_mux_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Truth-table model from arithmetic on the operand values: {and,or,not,nand,nor,xor,xnor}
   function automatic logic [6:0] ref_gates(input int x, input int y);
      int   s;
      int   p;
      logic an;
      logic o;
      logic n;
      logic xr;
      s  = x + y;
      p  = x * y;
      an = (p == 1);
      o  = (s > 0);
      n  = (x == 0);
      xr = (s == 1);
      return {an, o, n, !an, !o, xr, !xr};
   endfunction

   function automatic logic [6:0] observed();
      return {bus.and_out, bus.or_out, bus.not_out, bus.nand_out,
              bus.nor_out, bus.xor_out, bus.xnor_out};
   endfunction

   task automatic test_reset();
      logic [6:0] exp_v;
      rst   = 1'b1;
      bus.a = 1'b1;
      bus.b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (observed() !== 7'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=%b", observed(), 7'b0);
      end
      total++;
      if (bus.valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%b want=0", bus.valid);
      end
      @(negedge clk);
      bus.a = 1'b0;
      bus.b = 1'b0;
      rst   = 1'b0;
      #1;
      total++;
      if (bus.valid !== 1'b0) begin
         bad++;
         $display("FAIL valid_before_edge got=%b want=0", bus.valid);
      end
      @(posedge clk);
      #1;
      exp_v = ref_gates(0, 0);
      total++;
      if (observed() !== exp_v) begin
         bad++;
         $display("FAIL first_edge_00 got=%b want=%b", observed(), exp_v);
      end
      total++;
      if (bus.valid !== 1'b1) begin
         bad++;
         $display("FAIL valid_after_release got=%b want=1", bus.valid);
      end
   endtask

   task automatic test_async_reset();
      logic [6:0] exp_v;
      @(negedge clk);
      bus.a = 1'b1;
      bus.b = 1'b1;
      @(posedge clk);
      #1;
      exp_v = ref_gates(1, 1);
      total++;
      if (observed() !== exp_v) begin
         bad++;
         $display("FAIL pre_async_11 got=%b want=%b", observed(), exp_v);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({observed(), bus.valid} !== 8'b0) begin
         bad++;
         $display("FAIL async_clear got=%b want=%b", {observed(), bus.valid}, 8'b0);
      end
      @(negedge clk);
      bus.a = 1'b1;
      bus.b = 1'b0;
      rst   = 1'b0;
      @(posedge clk);
      #1;
      exp_v = ref_gates(1, 0);
      total++;
      if ({observed(), bus.valid} !== {exp_v, 1'b1}) begin
         bad++;
         $display("FAIL reload_after_reset got=%b want=%b", {observed(), bus.valid}, {exp_v, 1'b1});
      end
   endtask

   task automatic test_truth_table();
      logic [1:0] seq [6] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11};
      logic [6:0] exp_v;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.a = seq[i][1];
         bus.b = seq[i][0];
         @(posedge clk);
         #1;
         exp_v = ref_gates(int'(seq[i][1]), int'(seq[i][0]));
         total++;
         if ({observed(), bus.valid} !== {exp_v, 1'b1}) begin
            bad++;
            $display("FAIL truth_vec%0d ab=%b got=%b want=%b", i, seq[i],
                     {observed(), bus.valid}, {exp_v, 1'b1});
         end
      end
   endtask

   task automatic test_latency();
      logic [6:0] old_v;
      logic [6:0] new_v;
      @(negedge clk);
      bus.a = 1'b0;
      bus.b = 1'b1;
      @(posedge clk);
      old_v = ref_gates(0, 1);
      #1;
      bus.a = 1'b1;
      bus.b = 1'b0;
      #3;
      total++;
      if (observed() !== old_v) begin
         bad++;
         $display("FAIL latency_hold got=%b want=%b", observed(), old_v);
      end
      @(posedge clk);
      #1;
      new_v = ref_gates(1, 0);
      total++;
      if (observed() !== new_v) begin
         bad++;
         $display("FAIL latency_update got=%b want=%b", observed(), new_v);
      end
   endtask

   task automatic test_random();
      int         x;
      int         y;
      logic       exp_valid;
      logic [6:0] exp_v;
      exp_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         x = int'($urandom_range(1, 0));
         y = int'($urandom_range(1, 0));
         @(negedge clk);
         bus.a = x[0];
         bus.b = y[0];
         if ($urandom_range(15, 0) == 0) begin
            #1;
            rst = 1'b1;
            #1;
            total++;
            if ({observed(), bus.valid} !== 8'b0) begin
               bad++;
               $display("FAIL rand_mid_reset iter=%0d got=%b want=%b", i,
                        {observed(), bus.valid}, 8'b0);
            end
            rst = 1'b0;
         end
         @(posedge clk);
         #1;
         exp_v = ref_gates(x, y);
         total++;
         if ({observed(), bus.valid} !== {exp_v, exp_valid}) begin
            bad++;
            $display("FAIL rand iter=%0d ab=%0d%0d got=%b want=%b", i, x, y,
                     {observed(), bus.valid}, {exp_v, exp_valid});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.a = 1'b0;
      bus.b = 1'b0;
      test_reset();
      test_truth_table();
      test_latency();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
